// File: rtl/resp_serializer_pkg.sv
// Shared constants for the response serializer: default frame size, FSM
// encoding and the response codes carried in frame payloads.
package resp_serializer_pkg;

  localparam int MSG_BYTES_DEF = 5;

  // Leading byte of a payload, as produced by the match and aux paths.
  localparam logic [7:0] RESP_HIT      = 8'h48;
  localparam logic [7:0] RESP_FINISHED = 8'h46;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/resp_serializer.sv
// Round-robin arbiter between two response FIFOs that serializes one latched
// frame at a time, LSB byte first, onto a host UART.
module resp_serializer
  import resp_serializer_pkg::*;
#(
  parameter int MSG_BYTES = MSG_BYTES_DEF,
  parameter int CNT_W     = 16,
  localparam int MSG_W    = 8 * MSG_BYTES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [MSG_W-1:0] src0_msg,
  input  logic             src0_ready,
  output logic             src0_ack,
  input  logic [MSG_W-1:0] src1_msg,
  input  logic             src1_ready,
  output logic             src1_ack,
  output logic [7:0]       tx_byte,
  output logic             tx_req,
  input  logic             tx_busy,
  output logic [CNT_W-1:0] frame_count,
  output logic             active
);

  localparam int IDX_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;

  state_t           state, state_nx;
  logic [MSG_W-1:0] shift;
  logic [IDX_W-1:0] idx;
  logic             grant;     // current / last granted source (1 = src1)
  logic             grant_nx;
  logic             load, issue, fire;

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    issue    = 1'b0;
    fire     = 1'b0;
    // Tie goes to the source that did not win last time.
    grant_nx = (src0_ready && src1_ready) ? ~grant : src1_ready;
    case (state)
      ST_IDLE: if (src0_ready || src1_ready) begin
        load     = 1'b1;
        state_nx = ST_SEND;
      end
      // tx_req still high means the UART has not yet had a cycle to raise busy.
      ST_SEND: if (!tx_busy && !tx_req) begin
        issue = 1'b1;
        if (idx == IDX_W'(MSG_BYTES - 1)) state_nx = ST_DONE;
      end
      ST_DONE: if (!tx_busy && !tx_req) begin
        fire     = 1'b1;
        state_nx = ST_GAP;
      end
      ST_GAP:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant       <= 1'b1;
      shift       <= '0;
      idx         <= '0;
      tx_byte     <= '0;
      tx_req      <= 1'b0;
      src0_ack    <= 1'b0;
      src1_ack    <= 1'b0;
      frame_count <= '0;
    end else begin
      tx_req   <= issue;
      src0_ack <= fire & ~grant;
      src1_ack <= fire & grant;
      if (load) begin
        grant <= grant_nx;
        shift <= grant_nx ? src1_msg : src0_msg;
        idx   <= '0;
      end
      if (issue) begin
        tx_byte <= shift[7:0];
        shift   <= shift >> 8;
        idx     <= idx + 1'b1;
      end
      if (fire) frame_count <= frame_count + 1'b1;
    end
  end

  assign active = (state != ST_IDLE);

endmodule

// File: tb/tb_resp_serializer.sv
// Scoreboard bench: source FIFO models and a busy-UART model feed the DUT,
// a negedge monitor reassembles frames and checks them against expectations.
module tb_resp_serializer;
  localparam int MSG_BYTES = 5;
  localparam int MSG_W     = 8 * MSG_BYTES;
  localparam int CNT_W     = 4;

  typedef struct {
    bit               src;
    logic [MSG_W-1:0] msg;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [MSG_W-1:0] src0_msg, src1_msg;
  logic             src0_ready, src1_ready, src0_ack, src1_ack;
  logic [7:0]       tx_byte;
  logic             tx_req, tx_busy, active;
  logic [CNT_W-1:0] frame_count;

  resp_serializer #(.MSG_BYTES(MSG_BYTES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .src0_msg(src0_msg), .src0_ready(src0_ready), .src0_ack(src0_ack),
    .src1_msg(src1_msg), .src1_ready(src1_ready), .src1_ack(src1_ack),
    .tx_byte(tx_byte), .tx_req(tx_req), .tx_busy(tx_busy),
    .frame_count(frame_count), .active(active)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Source FIFO models: pop on ack, head/ready refreshed every edge.
  logic [MSG_W-1:0] q0[$], q1[$];
  always @(posedge clk) begin
    if (src0_ack && q0.size() != 0) void'(q0.pop_front());
    if (src1_ack && q1.size() != 0) void'(q1.pop_front());
    src0_ready <= (q0.size() != 0);
    src0_msg   <= (q0.size() != 0) ? q0[0] : '0;
    src1_ready <= (q1.size() != 0);
    src1_msg   <= (q1.size() != 0) ? q1[0] : '0;
  end

  task automatic refresh();
    src0_ready = (q0.size() != 0);
    src0_msg   = (q0.size() != 0) ? q0[0] : '0;
    src1_ready = (q1.size() != 0);
    src1_msg   = (q1.size() != 0) ? q1[0] : '0;
  endtask

  // UART model: busy for busy_len cycles after each request.
  int busy_len = 0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_req)            busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  exp_t exp_q[$];
  task automatic expect_frame(input bit src, input logic [MSG_W-1:0] msg);
    exp_t e;
    e.src = src;
    e.msg = msg;
    exp_q.push_back(e);
    if (src) q1.push_back(msg);
    else     q0.push_back(msg);
  endtask

  // Monitor
  logic [MSG_W-1:0] cur_msg;
  int               cur_n    = 0;
  logic [CNT_W-1:0] exp_fc   = '0;
  logic             req_prev = 1'b0;
  logic             busy_prev = 1'b0;
  int               req_total = 0;
  always @(negedge clk) begin
    if (reset) begin
      cur_n  = 0;
      exp_fc = '0;
    end else begin
      if (tx_req) begin
        req_total++;
        check("req_while_busy", {63'd0, busy_prev}, 64'd0);
        check("req_back_to_back", {63'd0, req_prev}, 64'd0);
        if (cur_n < MSG_BYTES) cur_msg[8*cur_n +: 8] = tx_byte;
        cur_n++;
      end
      if (src0_ack || src1_ack) begin
        exp_t e;
        check("dual_ack", {63'd0, src0_ack & src1_ack}, 64'd0);
        check("bytes_per_frame", 64'(cur_n), 64'(MSG_BYTES));
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_ack: got ack, expected no frame");
        end else begin
          e = exp_q.pop_front();
          check("ack_source", {63'd0, src1_ack}, {63'd0, e.src});
          check("frame_bytes", 64'(cur_msg), 64'(e.msg));
        end
        exp_fc = exp_fc + 1'b1;
        check("frame_count_step", 64'(frame_count), 64'(exp_fc));
        cur_n = 0;
      end
    end
    req_prev  = tx_req;
    busy_prev = tx_busy;
  end

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && !active && !tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {63'd0, ok}, 64'd1);
  endtask

  initial begin
    int seen;
    bit ok;
    reset = 1'b1;
    refresh();
    repeat (3) @(negedge clk);
    check("reset_tx_req", {63'd0, tx_req}, 64'd0);
    check("reset_tx_byte", 64'(tx_byte), 64'd0);
    check("reset_acks", {62'd0, src1_ack, src0_ack}, 64'd0);
    check("reset_frame_count", 64'(frame_count), 64'd0);
    check("reset_active", {63'd0, active}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single frame, minimum latency.
    expect_frame(1'b0, 40'h0A_1234_5678);
    refresh();
    @(posedge clk); @(posedge clk); #1;
    check("latency_tx_req", {63'd0, tx_req}, 64'd1);
    check("latency_first_byte", 64'(tx_byte), 64'h78);
    wait_idle("single_frame_done", 200);
    check("single_frame_count", 64'(frame_count), 64'd1);
    check("tx_byte_holds_last", 64'(tx_byte), 64'h0A);

    // Round-robin with both sources loaded.
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      expect_frame(1'b0, 40'hA0_0000_0000 | 40'(i));
      expect_frame(1'b1, 40'hB0_0000_0000 | 40'(i));
    end
    begin
      exp_t tmp[$];
      tmp = exp_q;
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(tmp[2*i]);
        exp_q.push_back(tmp[2*i+1]);
      end
    end
    refresh();
    wait_idle("round_robin_done", 1000);
    check("round_robin_count", 64'(frame_count), 64'd8);

    // Slow UART: one src1 frame with a long busy window.
    busy_len = 100;
    @(negedge clk);
    seen = req_total;
    expect_frame(1'b1, 40'h55_6677_8899);
    refresh();
    wait_idle("busy_frame_done", 2000);
    check("busy_req_count", 64'(req_total - seen), 64'd5);
    check("busy_frame_count", 64'(frame_count), 64'd9);
    busy_len = 0;

    // Source message overwritten after grant.
    @(negedge clk);
    expect_frame(1'b0, 40'h11_2233_4455);
    refresh();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (active) begin ok = 1'b1; break; end
    end
    check("grant_seen", {63'd0, ok}, 64'd1);
    @(negedge clk);
    q0[0] = '1;
    refresh();
    wait_idle("latched_frame_done", 200);
    check("latched_frame_count", 64'(frame_count), 64'd10);

    // Reset after the second byte; frame restarts from byte 0.
    @(negedge clk);
    seen = req_total;
    expect_frame(1'b0, 40'hC0_FFEE_1234);
    refresh();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_total - seen == 2) begin ok = 1'b1; break; end
    end
    check("two_bytes_before_reset", {63'd0, ok}, 64'd1);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (tx_req || src0_ack || src1_ack) seen++;
    end
    check("quiet_during_reset", 64'(seen), 64'd0);
    check("reset_mid_frame_count", 64'(frame_count), 64'd0);
    check("reset_mid_frame_active", {63'd0, active}, 64'd0);
    reset = 1'b0;
    wait_idle("restart_frame_done", 200);
    check("restart_frame_count", 64'(frame_count), 64'd1);

    // Sixteen frames from reset: counter wraps back to 0.
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      expect_frame(1'b0, 40'hD0_0000_0000 | 40'(i));
      expect_frame(1'b1, 40'hE0_0000_0000 | 40'(i));
    end
    refresh();
    wait_idle("wrap_frames_done", 2000);
    check("wrap_frame_count", 64'(frame_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/resp_serializer.md
RESP_SERIALIZER -- requirements
Module: resp_serializer

Interface
REQ-001 Parameter MSG_BYTES, default 5, bytes per response frame (MSG_W = 8*MSG_BYTES).
REQ-002 Parameter CNT_W, default 16, width of the frame counter.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 src0_msg  input  MSG_W  head entry of local match FIFO, valid while src0_ready.
REQ-006 src0_ready  input  1  local FIFO non-empty.
REQ-007 src0_ack  output  1  one-cycle pop pulse to local FIFO.
REQ-008 src1_msg  input  MSG_W  head entry of aux-UART FIFO, valid while src1_ready.
REQ-009 src1_ready  input  1  aux FIFO non-empty.
REQ-010 src1_ack  output  1  one-cycle pop pulse to aux FIFO.
REQ-011 tx_byte  output  8  byte to host UART.
REQ-012 tx_req  output  1  one-cycle transmit request.
REQ-013 tx_busy  input  1  UART transmitter busy.
REQ-014 frame_count  output  CNT_W  frames fully sent since reset, wraps.
REQ-015 active  output  1  high in any state except IDLE.

Function
REQ-016 States: IDLE, SEND, DONE, GAP.
REQ-017 IDLE: if any srcN_ready, grant one source, latch its msg into an internal MSG_W shift register, clear byte index, go SEND next cycle.
REQ-018 Arbitration round-robin: both ready -> grant the source not granted last; one ready -> grant it.
REQ-019 SEND: byte issued only when tx_busy==0 and tx_req was 0 in the previous cycle; issue = tx_byte <= shift[7:0], tx_req pulse 1 cycle, shift right 8, index+1.
REQ-020 Byte order LSB first: byte k = msg[8k+7:8k], k = 0..MSG_BYTES-1.
REQ-021 After byte MSG_BYTES-1 issued, go DONE.
REQ-022 DONE: when tx_busy==0 and tx_req was 0 previous cycle, pulse granted srcN_ack for exactly one cycle, frame_count+1 (mod 2^CNT_W), go GAP.
REQ-023 GAP: one idle cycle so FIFO ready reflects the pop, then IDLE; srcN_ready ignored in GAP.
REQ-024 src0_ack and src1_ack never high together; at most one ack per frame.
REQ-025 Latched message used for all bytes; source msg changes after grant have no effect.
REQ-026 Minimum latency: srcN_ready high in IDLE -> first tx_req 2 cycles later (grant edge, issue edge) when tx_busy==0.
REQ-027 tx_byte holds the last issued value between requests.
REQ-028 srcN_ready dropping during SEND/DONE does not abort; frame completes and ack still issues.

Reset
REQ-029 reset overrides all: state IDLE, tx_req 0, tx_byte 0, src0_ack 0, src1_ack 0, frame_count 0, active 0, last-grant = src1 (so src0 wins first tie).
REQ-030 reset mid-frame aborts the frame: no further bytes, no ack, frame_count unchanged except cleared to 0.

Structure
REQ-031 MSG_BYTES default, state encoding, and RESP_HIT/RESP_FINISHED codes live in the shared constants header.
REQ-032 Single flat module; no sub-module; instantiated between word_match_fifo/auxuart_fifo and the host uart, replacing inline top-level arbitration.

Verification
REQ-033 src0 msg 40'h0A_1234_5678 ready, tx_busy 0 -> tx_byte 78,56,34,12,0A in order, one src0_ack, frame_count 1.
REQ-034 src0 and src1 both ready for 4 frames each -> grant order 0,1,0,1,...; acks alternate; frame_count 8.
REQ-035 tx_busy held 1 for 100 cycles after each tx_req -> exactly 5 tx_req per frame, none while busy, none on consecutive cycles.
REQ-036 Source msg changed to 40'hFF..FF one cycle after grant -> transmitted bytes still the originally latched value.
REQ-037 reset asserted after 2nd byte -> no further tx_req, no ack, frame_count 0; next frame after reset starts at byte 0.
REQ-038 frame_count preset near wrap (CNT_W=4, 16 frames) -> wraps to 0, no other side effect.
